// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative multiplier, one partial-product step per clock (unsigned shift-add or Booth radix-2).
// Optional build macro MUL_EARLY_EXIT_EN: a zero operand bypasses the iterations and finishes in one cycle.
module seq_multiplier #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               Signed,
   input  logic [WIDTH-1:0]   Src1,
   input  logic [WIDTH-1:0]   Src2,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] Product
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   mcand_reg;
   logic [WIDTH-1:0]   mult_reg, mult_next;
   logic [WIDTH:0]     acc_reg, acc_next;
   logic               q_reg, q_next;
   logic               signed_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [2*WIDTH-1:0] product_reg;

   logic               accept;
   logic               zero_op;
   logic               last_iter;
   logic               do_add;
   logic               do_sub;
   logic [WIDTH:0]     mcand_ext;
   logic [WIDTH:0]     sum;

   assign accept    = start && (state_reg != S_CALC);
   assign last_iter = (state_reg == S_CALC) && (cnt_reg == CNT_W'(1));

`ifdef MUL_EARLY_EXIT_EN
   assign zero_op = (Src1 == '0) || (Src2 == '0);
`else
   assign zero_op = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = zero_op ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (cnt_reg == CNT_W'(1)) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (start) begin
               state_next = zero_op ? S_DONE : S_CALC;
            end else begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      ready = (state_reg == S_IDLE) || (state_reg == S_DONE);
      busy  = (state_reg == S_CALC);
      done  = (state_reg == S_DONE);
   end

   assign Product = product_reg;

   // One iteration: in unsigned mode the accumulator MSB is the carry and always shifts in as 0;
   // in signed mode it is the sign extension that keeps min*min exact.
   always_comb begin
      mcand_ext = {signed_reg & mcand_reg[WIDTH-1], mcand_reg};
      do_add    = signed_reg ? (!mult_reg[0] && q_reg) : mult_reg[0];
      do_sub    = signed_reg && mult_reg[0] && !q_reg;
      sum       = acc_reg;
      if (do_add) begin
         sum = acc_reg + mcand_ext;
      end else if (do_sub) begin
         sum = acc_reg - mcand_ext;
      end
      acc_next  = {signed_reg & sum[WIDTH], sum[WIDTH:1]};
      mult_next = {sum[0], mult_reg[WIDTH-1:1]};
      q_next    = mult_reg[0];
   end

   // Datapath registers; Product only changes when a result is complete
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_reg   <= '0;
         mult_reg    <= '0;
         acc_reg     <= '0;
         q_reg       <= 1'b0;
         signed_reg  <= 1'b0;
         cnt_reg     <= '0;
         product_reg <= '0;
      end else if (accept) begin
         mcand_reg  <= Src1;
         mult_reg   <= Src2;
         signed_reg <= Signed;
         acc_reg    <= '0;
         q_reg      <= 1'b0;
         cnt_reg    <= CNT_W'(WIDTH);
         if (zero_op) begin
            product_reg <= '0;
         end
      end else if (state_reg == S_CALC) begin
         acc_reg  <= acc_next;
         mult_reg <= mult_next;
         q_reg    <= q_next;
         cnt_reg  <= cnt_reg - CNT_W'(1);
         if (last_iter) begin
            product_reg <= {acc_next[WIDTH-1:0], mult_next};
         end
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier: a WIDTH=32 and a WIDTH=8 instance on a shared clock/reset.
module tb_seq_multiplier;

`ifdef MUL_EARLY_EXIT_EN
   localparam int LAT_ZERO8 = 0;
`else
   localparam int LAT_ZERO8 = 8;
`endif

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start, sgn;
   logic [31:0] src1, src2;
   logic        ready, busy, done;
   logic [63:0] product;

   logic        start8, sgn8;
   logic [7:0]  a8, b8;
   logic        ready8, busy8, done8;
   logic [15:0] product8;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_prev;
   logic [15:0] exp8_prev;
   int          dcount;

   seq_multiplier #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .start(start), .Signed(sgn), .Src1(src1), .Src2(src2),
      .ready(ready), .busy(busy), .done(done), .Product(product)
   );

   seq_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .Signed(sgn8), .Src1(a8), .Src2(b8),
      .ready(ready8), .busy(busy8), .done(done8), .Product(product8)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one 32-bit op; returns in the done cycle. poke>0 pulses start at that CALC cycle.
   task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp, input int poke);
      int n;
      start = 1'b1; src1 = a; src2 = b; sgn = s;
      step();
      start = 1'b0; src1 = $urandom; src2 = $urandom; sgn = 1'($urandom);
      check({tag, " busy"}, 64'(busy), 64'd1);
      check({tag, " hold"}, product, exp_prev);
      n = 0;
      while (!done && n < 100) begin
         if (poke > 0 && n == poke) begin
            start = 1'b1; src1 = 32'd2; src2 = 32'd2; sgn = 1'b0;
         end
         step();
         start = 1'b0;
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'd32);
      check({tag, " product"}, product, exp);
      exp_prev = exp;
      $display("op32 %s: 0x%h * 0x%h signed=%0d -> 0x%h after %0d cycles", tag, a, b, s, product, n);
   endtask

   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [15:0] exp, input int lat);
      int n;
      start8 = 1'b1; a8 = a; b8 = b; sgn8 = s;
      step();
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
      check({tag, " busy"}, 64'(busy8), (lat > 0) ? 64'd1 : 64'd0);
      if (lat > 0) begin
         check({tag, " hold"}, {48'h0, product8}, {48'h0, exp8_prev});
      end
      n = 0;
      while (!done8 && n < 100) begin
         step();
         n++;
      end
      check({tag, " latency"}, 64'(n), 64'(lat));
      check({tag, " product"}, {48'h0, product8}, {48'h0, exp});
      exp8_prev = exp;
      $display("op8 %s: 0x%h * 0x%h signed=%0d -> 0x%h after %0d cycles", tag, a, b, s, product8, n);
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; sgn = 1'b0; src1 = 32'd3; src2 = 32'd4;
      start8 = 1'b1; sgn8 = 1'b0; a8 = 8'd3; b8 = 8'd4;
      step();
      step();
      check("rst product", product, 64'h0);
      check("rst done", 64'(done), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst ready", 64'(ready), 64'd1);
      check("rst product8", {48'h0, product8}, 64'h0);
      rst = 1'b0; start = 1'b0; start8 = 1'b0;
      step();
      check("idle busy", 64'(busy), 64'd0);
      check("idle ready", 64'(ready), 64'd1);
      exp_prev = 64'h0;
      exp8_prev = 16'h0;

      op32("uns max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0);
      step();
      check("done pulse", 64'(done), 64'd0);
      check("ready after done", 64'(ready), 64'd1);
      op32("sgn -3*7", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0);
      step();
      op32("sgn min*min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
      step();
      op32("sgn max*min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, 0);
      step();

      op32("mid start", 32'd3, 32'd5, 1'b0, 64'd15, 10);
      step();
      check("no queue busy", 64'(busy), 64'd0);
      check("no queue ready", 64'(ready), 64'd1);

      op32("b2b first", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h1_0000_0000, 0);
      op32("b2b second", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1, 0);
      step();

      start = 1'b1; src1 = 32'd9; src2 = 32'd9; sgn = 1'b0;
      step();
      start = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort busy", 64'(busy), 64'd0);
      check("abort ready", 64'(ready), 64'd1);
      check("abort product", product, 64'h0);
      check("abort done", 64'(done), 64'd0);
      dcount = 0;
      repeat (40) begin
         step();
         if (done) dcount++;
      end
      check("abort no done", 64'(dcount), 64'd0);
      $display("abort: reset mid-op, %0d done pulses afterwards", dcount);
      exp_prev = 64'h0;
      op32("after abort", 32'd5, 32'd6, 1'b0, 64'd30, 0);
      step();

      op8("8 sgn min*-1", 8'h80, 8'hFF, 1'b1, 16'h0080, 8);
      step();
      op8("8 uns 128*255", 8'h80, 8'hFF, 1'b0, 16'h7F80, 8);
      step();
      op8("8 zero", 8'h55, 8'h00, 1'b0, 16'h0000, LAT_ZERO8);
      step();
      op8("8 sgn 127sq", 8'h7F, 8'h7F, 1'b1, 16'h3F01, 8);
      step();
      op8("8 sgn min*min", 8'h80, 8'h80, 1'b1, 16'h4000, 8);
      op8("8 uns 255sq b2b", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 8);
      step();
      check("8 done pulse", 64'(done8), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
